// File: rtl/mmio_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx_pkg
//   Shared bus package for the memory-mapped responders. It holds the register
//   offsets, the STATUS bit positions, the mem_data_width encodings, the UART
//   transmitter state type and the read-data sizing helper.
// -----------------------------------------------------------------------------
package mmio_uart_tx_pkg;

    // Register offsets, decoded on address[3:0]
    localparam logic [3:0] REG_TXDATA  = 4'h0;
    localparam logic [3:0] REG_STATUS  = 4'h4;
    localparam logic [3:0] REG_BAUDDIV = 4'h8;
    localparam logic [3:0] REG_RSVD    = 4'hC;

    // STATUS bit positions
    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 8;

    // mem_data_width encodings; 2'b11 is handled as a word access
    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Masks a value to the access width and sign- or zero-extends it.
    function automatic logic [31:0] size_read(input logic [31:0] value,
                                              input logic [1:0]  width,
                                              input logic        sign_ext);
        case (width)
            WIDTH_BYTE: return sign_ext ? {{24{value[7]}}, value[7:0]}
                                        : {24'h0, value[7:0]};
            WIDTH_HALF: return sign_ext ? {{16{value[15]}}, value[15:0]}
                                        : {16'h0, value[15:0]};
            default:    return value;
        endcase
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock show-ahead FIFO. o_data always presents the oldest entry.
//   A push while full is accepted only when a pop happens in the same cycle.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_push, i_data    write request and data
//   i_pop             remove the head entry (ignored when empty)
//   o_data            head entry
//   o_full, o_empty   occupancy flags
//   o_count           number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // NOTE: the storage array has no reset; only pointers and count do, so
    // stale entries are never visible and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped UART transmitter: TXDATA push, STATUS (W1C overflow),
//   BAUDDIV, a TX FIFO and an 8N1 serializer.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   write_enable, read_enable  bus requests, held until mem_ready
//   mem_signed_read            sign-extend sub-word reads
//   mem_data_width             00 byte, 01 half, 10/11 word
//   address, data_in           byte address (bits [3:0] decoded), write data
//   data_out                   read data, zero except while mem_ready=1
//   mem_ready                  one-cycle access-complete pulse
//   tx                         serial output, idle high
// -----------------------------------------------------------------------------
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int CLK_DIV_RESET = 434,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic        mem_signed_read,
    input  logic [1:0]  mem_data_width,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        mem_ready,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus side
    logic        r_mem_ready;
    logic        r_wait_release;
    logic [31:0] r_data_out;
    logic [15:0] r_bauddiv;
    logic        r_overflow;

    // Serializer
    tx_state_e   r_state;
    logic [15:0] r_div;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_tx;

    logic          w_req;
    logic          w_accept;
    logic [3:0]    w_addr;
    logic [31:0]   w_wdata;
    logic          w_wr_txdata;
    logic          w_wr_status;
    logic          w_wr_baud;
    logic [31:0]   w_status;
    logic [31:0]   w_reg_rdata;
    logic          w_push;
    logic          w_pop;
    logic          w_bit_end;
    logic [15:0]   w_div_load;
    logic [7:0]    w_fifo_data;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic          w_unused_bits;

    // An access is taken once; the enable must drop before the next one is
    // accepted, so a request held for many cycles still completes once.
    assign w_req    = write_enable | read_enable;
    assign w_accept = w_req & ~r_mem_ready & ~r_wait_release;
    assign w_addr   = address[3:0];
    assign w_wdata  = size_read(data_in, mem_data_width, 1'b0);

    // write_enable wins when both enables are high
    assign w_wr_txdata = w_accept & write_enable & (w_addr == REG_TXDATA);
    assign w_wr_status = w_accept & write_enable & (w_addr == REG_STATUS);
    assign w_wr_baud   = w_accept & write_enable & (w_addr == REG_BAUDDIV);

    // A full FIFO still takes the byte if the serializer pops this cycle.
    assign w_push = w_wr_txdata & (~w_fifo_full | w_pop);

    assign w_unused_bits = ^{address[31:4], w_wdata[31:16]};

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        w_status                      = '0;
        w_status[ST_BUSY]             = (r_state != TX_IDLE);
        w_status[ST_FULL]             = w_fifo_full;
        w_status[ST_EMPTY]            = w_fifo_empty;
        w_status[ST_OVERFLOW]         = r_overflow;
        w_status[ST_COUNT_LSB +: 8]   = 8'(w_fifo_count);
    end

    always_comb begin
        w_reg_rdata = '0;
        case (w_addr)
            REG_STATUS:  w_reg_rdata = w_status;
            REG_BAUDDIV: w_reg_rdata = {16'h0, r_bauddiv};
            default:     w_reg_rdata = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, matching the flop hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_ready    <= 1'b0;
            r_wait_release <= 1'b0;
            r_data_out     <= '0;
            r_bauddiv      <= 16'(CLK_DIV_RESET);
            r_overflow     <= 1'b0;
        end else begin
            r_mem_ready <= w_accept;
            r_data_out  <= (w_accept & ~write_enable)
                         ? size_read(w_reg_rdata, mem_data_width, mem_signed_read)
                         : '0;

            if (w_accept)   r_wait_release <= 1'b1;
            else if (!w_req) r_wait_release <= 1'b0;

            if (w_wr_baud) r_bauddiv <= w_wdata[15:0];

            if (w_wr_txdata && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (w_wr_status && data_in[ST_OVERFLOW]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (data_in[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // A divisor of zero would never end a bit period, so it runs as one.
    assign w_div_load = (r_bauddiv == 16'd0) ? 16'd1 : r_bauddiv;
    assign w_bit_end  = (r_cnt == r_div - 16'd1);

    // The empty flag is registered, so a byte pushed into an empty FIFO is
    // popped on the following cycle, never the same one.
    assign w_pop = ~w_fifo_empty &
                   ((r_state == TX_IDLE) | ((r_state == TX_STOP) & w_bit_end));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= TX_IDLE;
            r_div     <= 16'd1;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_fifo_data;
                        r_div   <= w_div_load;
                        r_cnt   <= '0;
                        r_tx    <= 1'b0;
                        r_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= TX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= TX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_pop) begin
                            // Back-to-back frame: reload without visiting IDLE
                            r_shift <= w_fifo_data;
                            r_div   <= w_div_load;
                            r_tx    <= 1'b0;
                            r_state <= TX_START;
                        end else begin
                            r_state <= TX_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign data_out  = r_data_out;
    assign mem_ready = r_mem_ready;
    assign tx        = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_mmio_uart_tx
//   Directed bench for mmio_uart_tx. Bytes accepted into TXDATA are queued as
//   expected frames; a line monitor decodes tx and pops the queue per frame.
// -----------------------------------------------------------------------------
module tb_mmio_uart_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic        mem_signed_read = 1'b0;
    logic [1:0]  mem_data_width = 2'b10;
    logic [31:0] address = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        mem_ready;
    logic        tx;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int         mon_div  = 4;
    bit         mon_en   = 1'b0;
    bit         mon_busy = 1'b0;

    mmio_uart_tx #(
        .CLK_DIV_RESET (434),
        .FIFO_DEPTH    (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .write_enable    (write_enable),
        .read_enable     (read_enable),
        .mem_signed_read (mem_signed_read),
        .mem_data_width  (mem_data_width),
        .address         (address),
        .data_in         (data_in),
        .data_out        (data_out),
        .mem_ready       (mem_ready),
        .tx              (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bus access. hold=0 drops the enable as soon as mem_ready is seen;
    // hold>0 keeps it high for that many cycles regardless.
    task automatic bus(input logic we, input logic re, input logic [1:0] w,
                       input logic sgn, input logic [31:0] a, input logic [31:0] d,
                       input int hold, output logic [31:0] rdata, output int pulses);
        bit seen;
        seen   = 1'b0;
        rdata  = '0;
        pulses = 0;
        @(negedge clk);
        write_enable    = we;
        read_enable     = re;
        mem_data_width  = w;
        mem_signed_read = sgn;
        address         = a;
        data_in         = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                if (!seen) rdata = data_out;
                seen = 1'b1;
                pulses++;
            end
            if (hold == 0 ? seen : (i + 1 >= hold)) break;
        end
        write_enable = 1'b0;
        read_enable  = 1'b0;
        check("mem_ready_seen", seen, 1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int p;
        bus(1'b1, 1'b0, 2'b10, 1'b0, a, d, 0, rd, p);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [1:0] w,
                          input logic sgn, input logic [31:0] exp);
        logic [31:0] rd;
        int p;
        bus(1'b0, 1'b1, w, sgn, a, 32'h0, 0, rd, p);
        check(tag, rd, exp);
    endtask

    task automatic tx_write(input logic [7:0] b, input bit accepted);
        wr(32'h0, {24'h0, b});
        if (accepted) exp_q.push_back(b);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mon_busy) break;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        repeat (mon_div + 2) @(negedge clk);
    endtask

    // Frame monitor: on a start bit, sample each bit at its centre.
    initial begin
        int d;
        logic [7:0] b;
        logic stop_v;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && tx === 1'b0) begin
                mon_busy = 1'b1;
                d = mon_div;
                repeat (d + d / 2) @(negedge clk);
                b[0] = tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = tx;
                end
                repeat (d) @(negedge clk);
                stop_v = tx;
                if (exp_q.size() == 0) check("unexpected_frame", exp_q.size(), 1);
                else check("tx_byte", b, exp_q.pop_front());
                check("stop_bit", stop_v, 1);
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [39:0] cap;
        logic [39:0] exp_v;
        logic [7:0]  pat;
        int p;
        int lows;
        bit found;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_data_out", data_out, 0);
        reset = 1'b0;
        @(negedge clk);

        rd_chk("status_after_reset", 32'h4, 2'b10, 1'b0, 32'h0000_0004);
        rd_chk("bauddiv_reset", 32'h8, 2'b10, 1'b0, 32'd434);
        @(negedge clk);
        check("data_out_idle", data_out, 0);
        rd_chk("bauddiv_ubyte", 32'h8, 2'b00, 1'b0, 32'h0000_00B2);
        rd_chk("bauddiv_sbyte", 32'h8, 2'b00, 1'b1, 32'hFFFF_FFB2);
        rd_chk("bauddiv_shalf", 32'h8, 2'b01, 1'b1, 32'h0000_01B2);
        rd_chk("bauddiv_w11", 32'h8, 2'b11, 1'b1, 32'h0000_01B2);
        rd_chk("txdata_read", 32'h0, 2'b10, 1'b0, 32'h0);
        wr(32'hC, 32'hDEAD_BEEF);
        rd_chk("reserved_read", 32'hC, 2'b10, 1'b0, 32'h0);
        check("rst_tx_idle", tx, 1);

        // ---------------- width/sign on BAUDDIV=0xFFFF ----------------
        wr(32'h8, 32'h0000_FFFF);
        rd_chk("ffff_sbyte", 32'h8, 2'b00, 1'b1, 32'hFFFF_FFFF);
        rd_chk("ffff_uhalf", 32'h8, 2'b01, 1'b0, 32'h0000_FFFF);
        rd_chk("ffff_shalf", 32'h8, 2'b01, 1'b1, 32'hFFFF_FFFF);

        // ---------------- 0x55 at BAUDDIV=4, cycle-exact waveform ----------------
        wr(32'h8, 32'd4);
        mon_en = 1'b0;
        wr(32'h0, 32'h55);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("start_bit_seen", found, 1);
        pat = 8'h55;
        for (int i = 0; i < 40; i++) begin
            if (i / 4 == 0)      exp_v[i] = 1'b0;
            else if (i / 4 == 9) exp_v[i] = 1'b1;
            else                 exp_v[i] = pat[i / 4 - 1];
        end
        cap[0] = tx;
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            cap[i] = tx;
        end
        check("frame_0x55_waveform", cap, exp_v);
        rd_chk("status_idle_after_frame", 32'h4, 2'b10, 1'b0, 32'h0000_0004);

        // ---------------- busy during frame, BAUDDIV change mid-frame ----------------
        mon_en  = 1'b1;
        mon_div = 4;
        tx_write(8'hC3, 1'b1);
        rd_chk("status_busy", 32'h4, 2'b10, 1'b0, 32'h0000_0005);
        wr(32'h8, 32'd8);
        drain(200);
        mon_div = 8;
        tx_write(8'h3C, 1'b1);
        drain(300);

        // ---------------- BAUDDIV=1, 9 back-to-back writes ----------------
        // Frames take 10 clocks and writes arrive every 2, so pops intervene
        // and the FIFO never overflows.
        wr(32'h8, 32'd1);
        mon_div = 1;
        for (int i = 0; i < 9; i++) tx_write(8'h30 + 8'(i), 1'b1);
        bus(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0, 0, rd, p);
        check("ovf_div1", rd[3], 0);
        drain(300);

        // ---------------- BAUDDIV=20, 10 writes: FIFO fills, 10th dropped ----------------
        wr(32'h8, 32'd20);
        mon_div = 20;
        for (int i = 0; i < 10; i++) tx_write(8'h40 + 8'(i), i < 9);
        rd_chk("status_overflow", 32'h4, 2'b10, 1'b0, 32'h0000_080B);
        wr(32'h4, 32'h8);
        rd_chk("status_w1c", 32'h4, 2'b10, 1'b0, 32'h0000_0803);
        drain(3000);

        // ---------------- requests held for 5 cycles ----------------
        bus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h11, 5, rd, p);
        check("hold_wr1_pulses", p, 1);
        exp_q.push_back(8'h11);
        bus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h22, 5, rd, p);
        check("hold_wr2_pulses", p, 1);
        exp_q.push_back(8'h22);
        bus(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0, 5, rd, p);
        check("hold_rd_pulses", p, 1);
        check("hold_status", rd, 32'h0000_0101);
        // both enables high is a write
        bus(1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'd20, 0, rd, p);
        check("both_en_rdata", rd, 0);
        drain(1000);

        // ---------------- reset during DATA bit 3 ----------------
        wr(32'h8, 32'd4);
        mon_en = 1'b0;
        wr(32'h0, 32'hA5);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("start_bit_seen_a5", found, 1);
        repeat (17) @(negedge clk);
        check("bit3_of_a5", tx, 0);
        reset = 1'b1;
        @(negedge clk);
        check("tx_after_reset", tx, 1);
        check("ready_after_reset", mem_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        rd_chk("status_after_abort", 32'h4, 2'b10, 1'b0, 32'h0000_0004);
        rd_chk("bauddiv_after_abort", 32'h8, 2'b10, 1'b0, 32'd434);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("no_frame_after_reset", lows, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV_RESET, default 434, giving the reset value of BAUDDIV (clocks per serial bit).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, giving TX FIFO entries (power of two, 2..64).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port write_enable  input  1  bus write request, held by initiator until mem_ready.
REQ-006 SHALL have port read_enable  input  1  bus read request, held by initiator until mem_ready.
REQ-007 SHALL have port mem_signed_read  input  1  sign-extend sub-word read data.
REQ-008 SHALL have port mem_data_width  input  2  00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-009 SHALL have port address  input  32  byte address; only address[3:0] decoded.
REQ-010 SHALL have port data_in  input  32  write data, right-aligned.
REQ-011 SHALL have port data_out  output  32  read data, valid while mem_ready=1.
REQ-012 SHALL have port mem_ready  output  1  one-cycle access-complete pulse.
REQ-013 SHALL have port tx  output  1  UART serial output, idle high.

Function
REQ-014 SHALL map registers: 0x0 TXDATA (W: push data_in[7:0]; R: 0), 0x4 STATUS (R/W1C), 0x8 BAUDDIV (R/W, [15:0]), 0xC reserved (R: 0, W: ignored).
REQ-015 SHALL define STATUS bits: [0] busy (FSM not IDLE), [1] fifo_full, [2] fifo_empty, [3] overflow (sticky), [15:8] FIFO count, others 0.
REQ-016 SHALL assert mem_ready exactly one cycle after the first cycle an enable is sampled high, for one cycle, then hold it low for at least one cycle before accepting the next request.
REQ-017 SHALL perform the register side effect once per access, in the cycle mem_ready is asserted.
REQ-018 SHALL treat read_enable and write_enable both high as a write.
REQ-019 SHALL, on reads, return the register value masked to the access width, sign-extended from bit 7/15 when mem_signed_read=1, else zero-extended; data_out=0 when mem_ready=0.
REQ-020 SHALL drop a TXDATA write when the FIFO is full, set overflow, and still assert mem_ready.
REQ-021 SHALL clear overflow on a STATUS write with data_in[3]=1; other STATUS bits are unaffected by writes.
REQ-022 SHALL accept a TXDATA push when the FIFO is full and a pop occurs in the same cycle.
REQ-023 SHALL not pop in the same cycle as a push into an empty FIFO; the pop occurs the following cycle.
REQ-024 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-025 SHALL transition IDLE->START when the FIFO is non-empty, popping one byte into the shift register and latching BAUDDIV (value 0 latched as 1).
REQ-026 SHALL drive tx=0 for one bit period in START, 8 data bits LSB first in DATA, tx=1 for one bit period in STOP, then go to IDLE (or directly to START if the FIFO is non-empty).
REQ-027 SHALL make each bit period exactly the latched divisor in clocks; BAUDDIV writes mid-frame take effect at the next frame.
REQ-028 SHALL hold tx=1 in IDLE.

Reset
REQ-029 SHALL, while reset=1 at a clock edge, set tx=1, mem_ready=0, data_out=0, FSM=IDLE, FIFO empty, overflow=0, BAUDDIV=CLK_DIV_RESET.
REQ-030 SHALL abort any frame or pending bus access on reset; tx=1 from the cycle after reset is sampled.

Structure
REQ-031 SHALL take register offsets, STATUS bit positions and mem_data_width encodings from the shared bus package used by all memory-mapped responders.
REQ-032 SHALL instantiate one sub-module, sync_fifo (8-bit data, FIFO_DEPTH entries, push/pop/full/empty/count).

Verification
REQ-033 SHALL cover: reset, read STATUS word -> data_out=0x00000004, tx=1, BAUDDIV read = 434.
REQ-034 SHALL cover: BAUDDIV=4, write 0x55 to TXDATA -> tx low 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, stop high 4 clocks; busy=1 throughout.
REQ-035 SHALL cover: BAUDDIV=1, 9 back-to-back TXDATA writes with FIFO_DEPTH=8 -> overflow=1 only if no pop intervened; W1C 0x8 to STATUS -> overflow=0.
REQ-036 SHALL cover: write BAUDDIV=0xFFFF, signed byte read of 0x8 -> 0xFFFFFFFF; unsigned halfword read -> 0x0000FFFF.
REQ-037 SHALL cover: reset asserted during DATA bit 3 -> tx=1 next cycle, STATUS=0x4, no further frame output.
REQ-038 SHALL cover: every access held for 5 cycles -> exactly one mem_ready pulse and one FIFO push per access.
